// File: rtl/mdu_div_sequencer_pkg.sv
// Shared types, encodings and helpers for the hardisc EX-stage multiply/divide unit.
package p_hardisc;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    DONE = 2'b10
  } div_state;

  typedef logic [1:0] f_part;

  localparam f_part MDU_DIV  = 2'b00;
  localparam f_part MDU_DIVU = 2'b01;
  localparam f_part MDU_REM  = 2'b10;
  localparam f_part MDU_REMU = 2'b11;

  localparam int DIV_CNT_W = 5;

  function automatic logic [31:0] f_cond_neg(input logic [31:0] value, input logic neg);
    return neg ? (~value + 32'd1) : value;
  endfunction

  function automatic logic f_is_signed(input f_part fn);
    return (fn == MDU_DIV) || (fn == MDU_REM);
  endfunction

  function automatic logic f_is_rem(input f_part fn);
    return (fn == MDU_REM) || (fn == MDU_REMU);
  endfunction

endpackage

// File: rtl/mdu_div_sequencer_if.sv
// EX-stage handshake and data bundle between the pipeline and the divide sequencer.
interface mdu_div_sequencer_if;
  import p_hardisc::*;

  logic        s_start_i;
  logic        s_flush_i;
  logic        s_stall_i;
  f_part       s_function_i;
  logic [31:0] s_operand1_i;
  logic [31:0] s_operand2_i;
  logic        s_finished_o;
  logic [31:0] s_result_o;
  logic        s_busy_o;

  modport slave (
    input  s_start_i, s_flush_i, s_stall_i, s_function_i, s_operand1_i, s_operand2_i,
    output s_finished_o, s_result_o, s_busy_o
  );

  modport master (
    output s_start_i, s_flush_i, s_stall_i, s_function_i, s_operand1_i, s_operand2_i,
    input  s_finished_o, s_result_o, s_busy_o
  );

endinterface

// File: rtl/mdu_div_sequencer_seu_regs.sv
// Labelled register bank (N words of W bits) that fault-injection campaigns target by LABEL.
module seu_regs #(
  parameter string LABEL = "NONE",
  parameter int    W     = 1,
  parameter int    N     = 1
) (
  input  logic                s_c_i,
  input  logic                s_r_i,
  input  logic [N-1:0][W-1:0] s_d_i,
  output logic [N-1:0][W-1:0] s_q_o
);

  logic [N-1:0][W-1:0] regs_q;

  // Bank storage, cleared asynchronously by the active-low reset.
  always_ff @(posedge s_c_i or negedge s_r_i) begin
    if (!s_r_i) begin
      regs_q <= '0;
    end else begin
      regs_q <= s_d_i;
    end
  end

  assign s_q_o = regs_q;

  // An empty label marks a bank the injection campaign does not address.
  if (LABEL == "") begin : g_unlabeled
  end

endmodule

// File: rtl/mdu_div_sequencer.sv
// Radix-2 restoring divider sequencer for DIV/DIVU/REM/REMU; one quotient bit per cycle,
// divide-by-zero and signed overflow resolve combinationally in IDLE.
module mdu_div_sequencer
  import p_hardisc::*;
(
  input  logic                s_clk_i,
  input  logic                s_resetn_i,
  mdu_div_sequencer_if.slave  bus
);

  div_state             state_q, state_d;
  logic [1:0]           state_raw_s;
  logic [DIV_CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]          dvd_q, dvd_d;
  logic [31:0]          rem_q, rem_d;
  logic [31:0]          dsr_q, dsr_d;
  logic                 qneg_q, qneg_d;
  logic                 rneg_q, rneg_d;
  f_part                fn_q, fn_d;
  logic [31:0]          res_q, res_d;

  logic                 op_signed_s, dsr_zero_s, ovf_s, special_s, idle_req_s, fire_special_s;
  logic [31:0]          spec_res_s;
  logic [32:0]          rem_sh_s, diff_s;
  logic                 qbit_s;
  logic [31:0]          quot_nx_s, rem_nx_s;

  seu_regs #(.LABEL("DIV_ST"),  .W(2),         .N(1)) u_div_st  (.s_c_i(s_clk_i), .s_r_i(s_resetn_i), .s_d_i(state_d), .s_q_o(state_raw_s));
  seu_regs #(.LABEL("DIV_CNT"), .W(DIV_CNT_W), .N(1)) u_div_cnt (.s_c_i(s_clk_i), .s_r_i(s_resetn_i), .s_d_i(cnt_d),   .s_q_o(cnt_q));
  seu_regs #(.LABEL("DIV_DVD"), .W(32),        .N(1)) u_div_dvd (.s_c_i(s_clk_i), .s_r_i(s_resetn_i), .s_d_i(dvd_d),   .s_q_o(dvd_q));
  seu_regs #(.LABEL("DIV_REM"), .W(32),        .N(1)) u_div_rem (.s_c_i(s_clk_i), .s_r_i(s_resetn_i), .s_d_i(rem_d),   .s_q_o(rem_q));
  seu_regs #(.LABEL("DIV_DSR"), .W(32),        .N(1)) u_div_dsr (.s_c_i(s_clk_i), .s_r_i(s_resetn_i), .s_d_i(dsr_d),   .s_q_o(dsr_q));

  assign state_q = div_state'(state_raw_s);

  // Sign/function context and the DONE result register.
  always_ff @(posedge s_clk_i or negedge s_resetn_i) begin
    if (!s_resetn_i) begin
      qneg_q <= 1'b0;
      rneg_q <= 1'b0;
      fn_q   <= MDU_DIV;
      res_q  <= 32'd0;
    end else begin
      qneg_q <= qneg_d;
      rneg_q <= rneg_d;
      fn_q   <= fn_d;
      res_q  <= res_d;
    end
  end

  // Special-operand detection on the live EX operands.
  always_comb begin
    op_signed_s = f_is_signed(bus.s_function_i);
    dsr_zero_s  = (bus.s_operand2_i == 32'd0);
    ovf_s       = op_signed_s && (bus.s_operand1_i == 32'h8000_0000) && (bus.s_operand2_i == 32'hFFFF_FFFF);
    special_s   = dsr_zero_s || ovf_s;
    idle_req_s  = (state_q == IDLE) && bus.s_start_i && !bus.s_flush_i;
    fire_special_s = idle_req_s && special_s;
    if (dsr_zero_s) begin
      spec_res_s = f_is_rem(bus.s_function_i) ? bus.s_operand1_i : 32'hFFFF_FFFF;
    end else begin
      spec_res_s = f_is_rem(bus.s_function_i) ? 32'd0 : 32'h8000_0000;
    end
  end

  // One restoring step; bit 32 of the 33-bit difference is set exactly when rem' < divisor.
  always_comb begin
    rem_sh_s  = {rem_q, dvd_q[31]};
    diff_s    = rem_sh_s - {1'b0, dsr_q};
    qbit_s    = ~diff_s[32];
    rem_nx_s  = qbit_s ? diff_s[31:0] : rem_sh_s[31:0];
    quot_nx_s = {dvd_q[30:0], qbit_s};
  end

  // Next-state and datapath update; the quotient accumulates in the dividend register.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dvd_d   = dvd_q;
    rem_d   = rem_q;
    dsr_d   = dsr_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    fn_d    = fn_q;
    res_d   = res_q;
    case (state_q)
      IDLE: begin
        if (idle_req_s && !special_s) begin
          state_d = CALC;
          cnt_d   = DIV_CNT_W'(31);
          dvd_d   = f_cond_neg(bus.s_operand1_i, op_signed_s && bus.s_operand1_i[31]);
          dsr_d   = f_cond_neg(bus.s_operand2_i, op_signed_s && bus.s_operand2_i[31]);
          rem_d   = 32'd0;
          qneg_d  = op_signed_s && (bus.s_operand1_i[31] ^ bus.s_operand2_i[31]);
          rneg_d  = op_signed_s && bus.s_operand1_i[31];
          fn_d    = bus.s_function_i;
        end else begin
          state_d = IDLE;
        end
      end
      CALC: begin
        dvd_d = quot_nx_s;
        rem_d = rem_nx_s;
        if (cnt_q == DIV_CNT_W'(0)) begin
          state_d = DONE;
          res_d   = f_is_rem(fn_q) ? f_cond_neg(rem_nx_s, rneg_q) : f_cond_neg(quot_nx_s, qneg_q);
        end else begin
          cnt_d = cnt_q - DIV_CNT_W'(1);
        end
      end
      DONE: begin
        if (!bus.s_stall_i) begin
          state_d = IDLE;
        end else begin
          state_d = DONE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    if (bus.s_flush_i) begin
      state_d = IDLE;
    end else begin
      state_d = state_d;
    end
  end

  assign bus.s_finished_o = (state_q == DONE) || fire_special_s;
  assign bus.s_result_o   = (state_q == DONE) ? res_q : (fire_special_s ? spec_res_s : 32'd0);
  assign bus.s_busy_o     = (state_q != IDLE);

endmodule

// File: tb/tb_mdu_div_sequencer.sv
// Directed bench for mdu_div_sequencer: latency, results, specials, flush, stall and reset.
module tb_mdu_div_sequencer;
  import p_hardisc::*;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_pass   = 0;

  mdu_div_sequencer_if bus();

  mdu_div_sequencer dut (
    .s_clk_i    (clk),
    .s_resetn_i (rst_n),
    .bus        (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_div(input string tag, input f_part fn, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp, input int exp_lat);
    int lat;
    lat = 0;
    bus.s_function_i = fn;
    bus.s_operand1_i = a;
    bus.s_operand2_i = b;
    bus.s_start_i    = 1'b1;
    #1;
    while (bus.s_finished_o !== 1'b1 && lat < 40) begin
      tick();
      lat++;
      if (lat == 1) begin
        bus.s_operand1_i = 32'hDEAD_BEEF;
        bus.s_operand2_i = 32'h0000_0003;
      end
    end
    check_value({tag, " latency"}, 32'(lat), 32'(exp_lat));
    check_value({tag, " result"}, bus.s_result_o, exp);
    bus.s_start_i = 1'b0;
    tick();
    check_value({tag, " idle after"}, {31'd0, bus.s_busy_o}, 32'd0);
    check_value({tag, " no finish after"}, {31'd0, bus.s_finished_o}, 32'd0);
  endtask

  initial begin
    int  lat;
    logic saw_fin;
    bus.s_start_i    = 1'b0;
    bus.s_flush_i    = 1'b0;
    bus.s_stall_i    = 1'b0;
    bus.s_function_i = MDU_DIVU;
    bus.s_operand1_i = 32'd0;
    bus.s_operand2_i = 32'd1;
    repeat (2) @(posedge clk);
    #1;
    check_value("reset finished", {31'd0, bus.s_finished_o}, 32'd0);
    check_value("reset result", bus.s_result_o, 32'd0);
    check_value("reset busy", {31'd0, bus.s_busy_o}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    run_div("divu 100/7", MDU_DIVU, 32'd100, 32'd7, 32'd14, 33);
    run_div("remu 100/7", MDU_REMU, 32'd100, 32'd7, 32'd2, 33);
    run_div("div -7/2", MDU_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33);
    run_div("rem -7/2", MDU_REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33);
    run_div("div 100/-7", MDU_DIV, 32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF2, 33);
    run_div("divu 0xffffffff/1", MDU_DIVU, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 33);
    run_div("divu 5/0", MDU_DIVU, 32'd5, 32'd0, 32'hFFFF_FFFF, 0);
    run_div("remu 5/0", MDU_REMU, 32'd5, 32'd0, 32'd5, 0);
    run_div("div ovf", MDU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 0);
    run_div("rem ovf", MDU_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 0);
    run_div("divu no ovf", MDU_DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 33);

    // Flush coincident with a special-case start suppresses everything.
    bus.s_function_i = MDU_DIVU;
    bus.s_operand1_i = 32'd5;
    bus.s_operand2_i = 32'd0;
    bus.s_start_i    = 1'b1;
    bus.s_flush_i    = 1'b1;
    #1;
    check_value("flush+start finished", {31'd0, bus.s_finished_o}, 32'd0);
    check_value("flush+start result", bus.s_result_o, 32'd0);
    tick();
    check_value("flush+start busy", {31'd0, bus.s_busy_o}, 32'd0);
    bus.s_start_i = 1'b0;
    bus.s_flush_i = 1'b0;
    tick();

    // Flush in CALC at cycle 10, new DIVU 9/3 at cycle 11.
    bus.s_operand2_i = 32'd7;
    bus.s_operand1_i = 32'd100;
    bus.s_start_i    = 1'b1;
    saw_fin = 1'b0;
    #1;
    for (int c = 0; c < 10; c++) begin
      if (bus.s_finished_o) saw_fin = 1'b1;
      tick();
    end
    check_value("calc busy c10", {31'd0, bus.s_busy_o}, 32'd1);
    check_value("calc result gated", bus.s_result_o, 32'd0);
    bus.s_flush_i = 1'b1;
    #1;
    if (bus.s_finished_o) saw_fin = 1'b1;
    tick();
    bus.s_flush_i = 1'b0;
    bus.s_start_i = 1'b0;
    check_value("flush no finish", {31'd0, saw_fin}, 32'd0);
    check_value("flush busy c11", {31'd0, bus.s_busy_o}, 32'd0);
    run_div("divu 9/3 after flush", MDU_DIVU, 32'd9, 32'd3, 32'd3, 33);

    // Stall in CALC is ignored; stall on DONE entry holds the result for 4 cycles.
    bus.s_function_i = MDU_DIVU;
    bus.s_operand1_i = 32'd100;
    bus.s_operand2_i = 32'd7;
    bus.s_start_i    = 1'b1;
    lat = 0;
    #1;
    while (bus.s_finished_o !== 1'b1 && lat < 40) begin
      bus.s_stall_i = (lat >= 5 && lat < 9);
      tick();
      lat++;
    end
    check_value("stall latency", 32'(lat), 32'd33);
    for (int i = 0; i < 4; i++) begin
      bus.s_stall_i = (i < 3);
      #1;
      check_value("stall hold finished", {31'd0, bus.s_finished_o}, 32'd1);
      check_value("stall hold result", bus.s_result_o, 32'd14);
      tick();
    end
    bus.s_stall_i = 1'b0;
    bus.s_start_i = 1'b0;
    #1;
    check_value("stall release idle", {31'd0, bus.s_busy_o}, 32'd0);
    tick();

    // Asynchronous reset at cycle 20 of CALC.
    bus.s_start_i = 1'b1;
    #1;
    repeat (20) tick();
    check_value("pre-reset busy", {31'd0, bus.s_busy_o}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_value("async reset finished", {31'd0, bus.s_finished_o}, 32'd0);
    check_value("async reset result", bus.s_result_o, 32'd0);
    check_value("async reset busy", {31'd0, bus.s_busy_o}, 32'd0);
    bus.s_start_i = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    run_div("divu 100/7 after reset", MDU_DIVU, 32'd100, 32'd7, 32'd14, 33);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
